// File: rtl/router_sync_multi.sv
// Router FSM to NUM_CH output FIFO synchroniser: address latch, one-hot write steer, full mux, stall timeout.
// Optional per-channel soft_reset pulse counters when ROUTER_SYNC_SRST_CNT_EN is defined.
module router_sync_multi #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                detect_add,
  input  logic [ADDR_W-1:0]   data_in,
  input  logic                write_enb_reg,
  input  logic [NUM_CH-1:0]   full,
  input  logic [NUM_CH-1:0]   empty,
  input  logic [NUM_CH-1:0]   read_enb,
  output logic [NUM_CH-1:0]   write_enb,
  output logic                fifo_full,
  output logic                addr_err,
  output logic [NUM_CH-1:0]   vld_out,
`ifdef ROUTER_SYNC_SRST_CNT_EN
  output logic [NUM_CH*8-1:0] srst_cnt,
`endif
  output logic [NUM_CH-1:0]   soft_reset
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [ADDR_W-1:0] addr_reg;
  logic              addr_vld;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] fire;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_reg <= '0;
      addr_vld <= 1'b0;
    end else if (detect_add) begin
      addr_reg <= data_in;
      addr_vld <= 1'b1;
    end
  end

  // Decode straight off the register so a same-cycle detect_add still steers to the old address.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_vld && addr_reg == ADDR_W'(i)) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign addr_err = addr_vld && ({1'b0, addr_reg} >= (ADDR_W + 1)'(NUM_CH));
  assign vld_out  = ~empty;

  always_comb begin
    fire = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fire[i] = vld_out[i] && !read_enb[i] && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      soft_reset <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (read_enb[i] || !vld_out[i] || fire[i]) cnt[i] <= '0;
        else                                       cnt[i] <= cnt[i] + 1'b1;
      end
      soft_reset <= fire;
    end
  end

`ifdef ROUTER_SYNC_SRST_CNT_EN
  logic [7:0] pulse_cnt [NUM_CH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) pulse_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (fire[i] && pulse_cnt[i] != 8'hFF) pulse_cnt[i] <= pulse_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    srst_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) srst_cnt[8*i +: 8] = pulse_cnt[i];
  end
`endif

endmodule

// File: tb/tb_router_sync_multi.sv
// Directed bench for router_sync_multi (NUM_CH=3, ADDR_W=2, TIMEOUT=30).
module tb_router_sync_multi;

  logic       clock = 1'b0;
  logic       reset;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic [2:0] full, empty, read_enb;
  logic [2:0] write_enb, vld_out, soft_reset;
  logic       fifo_full, addr_err;
`ifdef ROUTER_SYNC_SRST_CNT_EN
  logic [23:0] srst_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic bad;

  router_sync_multi #(.NUM_CH(3), .ADDR_W(2), .TIMEOUT(30)) dut (
    .clock(clock), .reset(reset), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg), .full(full), .empty(empty), .read_enb(read_enb),
    .write_enb(write_enb), .fifo_full(fifo_full), .addr_err(addr_err), .vld_out(vld_out),
`ifdef ROUTER_SYNC_SRST_CNT_EN
    .srst_cnt(srst_cnt),
`endif
    .soft_reset(soft_reset)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n edges and flag any soft_reset activity seen along the way.
  task automatic quiet_ticks(input int n);
    bad = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (soft_reset !== 3'b000) bad = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1; detect_add = 1'b0; data_in = 2'd0; write_enb_reg = 1'b1;
    full = 3'b111; empty = 3'b010; read_enb = 3'b000;
    #3;
    check("rst_write_enb", write_enb, 3'b000);
    check("rst_fifo_full", fifo_full, 1'b0);
    check("rst_addr_err", addr_err, 1'b0);
    check("rst_soft_reset", soft_reset, 3'b000);
    check("rst_vld_out", vld_out, 3'b101);
    empty = 3'b111;
    tick();
    reset = 1'b0;

    // No address latched yet: nothing steered
    tick();
    check("noaddr_write_enb", write_enb, 3'b000);
    check("noaddr_fifo_full", fifo_full, 1'b0);
    check("noaddr_addr_err", addr_err, 1'b0);

    // Latch address 2, then write
    write_enb_reg = 1'b0; detect_add = 1'b1; data_in = 2'd2;
    tick();
    detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b100;
    #1;
    check("a2_write_enb", write_enb, 3'b100);
    check("a2_fifo_full", fifo_full, 1'b1);
    full = 3'b011;
    #1;
    check("a2_fifo_notfull", fifo_full, 1'b0);

    // Out-of-range address 3
    write_enb_reg = 1'b0; detect_add = 1'b1; data_in = 2'd3; full = 3'b111;
    tick();
    detect_add = 1'b0; write_enb_reg = 1'b1;
    #1;
    check("a3_addr_err", addr_err, 1'b1);
    check("a3_write_enb", write_enb, 3'b000);
    check("a3_fifo_full", fifo_full, 1'b0);

    // Same-cycle re-latch: old address steers this cycle
    write_enb_reg = 1'b0; detect_add = 1'b1; data_in = 2'd0;
    tick();
    check("a0_addr_err_clear", addr_err, 1'b0);
    data_in = 2'd1; write_enb_reg = 1'b1;
    #1;
    check("same_cycle_old", write_enb, 3'b001);
    tick();
    detect_add = 1'b0;
    #1;
    check("same_cycle_new", write_enb, 3'b010);
    write_enb_reg = 1'b0;

    // Stall channel 1: pulse after edge 30, again after edge 60
    empty = 3'b101;
    quiet_ticks(29);
    check("stall_no_early_pulse", bad, 1'b0);
    tick();
    check("stall_pulse1", soft_reset, 3'b010);
    quiet_ticks(29);
    check("stall_gap_quiet", bad, 1'b0);
    tick();
    check("stall_pulse2", soft_reset, 3'b010);

    // Read at edge 29 restarts the count
    read_enb = 3'b010;
    tick();
    check("read_clears_pulse", soft_reset, 3'b000);
    read_enb = 3'b000;
    quiet_ticks(29);
    read_enb = 3'b010;
    tick();
    check("read_at_29_quiet", (bad || soft_reset !== 3'b000), 1'b0);
    read_enb = 3'b000;
    quiet_ticks(29);
    check("after_read_quiet", bad, 1'b0);
    tick();
    check("after_read_pulse", soft_reset, 3'b010);

    // Async reset clears a live pulse immediately
    reset = 1'b1;
    #1;
    check("async_rst_pulse", soft_reset, 3'b000);
    tick();
    reset = 1'b0;

    // Reset at stall edge 20: count restarts from zero on release
    quiet_ticks(20);
    reset = 1'b1;
    #1;
    check("mid_rst_soft_reset", soft_reset, 3'b000);
    write_enb_reg = 1'b1;
    #1;
    check("mid_rst_addr_cleared", write_enb, 3'b000);
    write_enb_reg = 1'b0;
    tick();
    reset = 1'b0;
    quiet_ticks(29);
    check("post_rst_quiet", bad, 1'b0);
    tick();
    check("post_rst_pulse", soft_reset, 3'b010);

`ifdef ROUTER_SYNC_SRST_CNT_EN
    reset = 1'b1;
    #1;
    check("cnt_rst", srst_cnt, 24'h0);
    tick();
    reset = 1'b0;
    empty = 3'b110;
    for (int k = 0; k < 60; k++) tick();
    check("cnt_two", srst_cnt[7:0], 8'd2);
    for (int k = 0; k < 298 * 30 + 10; k++) tick();
    check("cnt_sat", srst_cnt[7:0], 8'd255);
    check("cnt_ch1_idle", srst_cnt[15:8], 8'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
